// File: rtl/multicycle_ctrl.sv
// LEGv8 multi-cycle control unit: sequences fetch/decode/execute/memory/write-back
// with ready handshakes, memory timeout, exception pulses and cycle/retire counters.
module multicycle_ctrl #(
  parameter int OP_W        = 11,
  parameter int IMM_EN      = 1,
  parameter int CNT_W       = 32,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  Op,
  input  logic             Zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             IMemReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic             ExcInvalid,
  output logic             ExcBusErr,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_ADDR, S_MEM, S_WB_R, S_WB_L, S_EXEC_BR
  } state_t;

  typedef enum logic [2:0] {
    C_INV, C_R, C_IMM, C_LD, C_ST, C_CBZ, C_B
  } cls_t;

  state_t           r_state;
  state_t           w_next;
  cls_t             r_cls;
  cls_t             w_cls;
  logic [TMO_W-1:0] r_wait;
  logic             w_wait;
  logic             w_tmo;

  // case-inside never treats X/Z in Op as wildcards, so unknown opcodes land on C_INV
  always_comb begin
    w_cls = C_INV;
    case (Op) inside
      11'b11111000010:                 w_cls = C_LD;
      11'b11111000000:                 w_cls = C_ST;
      11'b10110100???:                 w_cls = C_CBZ;
      11'b000101?????:                 w_cls = C_B;
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: w_cls = C_R;
      11'b1001000100?, 11'b1101000100?: w_cls = (IMM_EN != 0) ? C_IMM : C_INV;
      default:                         w_cls = C_INV;
    endcase
  end

  assign w_wait = ((r_state == S_FETCH) && !imem_ready) ||
                  ((r_state == S_MEM)   && !dmem_ready);
  assign w_tmo  = w_wait && (r_wait == TMO_W'(MEM_TIMEOUT - 1));

  // Outputs are combinational: handshake strobes must react in the same cycle as ready.
  always_comb begin
    w_next     = r_state;
    IMemReq    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUOp      = 2'b00;
    ExcInvalid = 1'b0;
    ExcBusErr  = 1'b0;
    case (r_state)
      S_FETCH: begin
        IMemReq = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_tmo) begin
          ExcBusErr = 1'b1;
        end
      end
      S_DECODE: begin
        case (w_cls)
          C_R, C_IMM:  w_next = S_EXEC_R;
          C_LD, C_ST:  w_next = S_EXEC_ADDR;
          C_CBZ:       w_next = S_EXEC_BR;
          C_B: begin
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
            w_next  = S_FETCH;
          end
          default: begin
            ExcInvalid = 1'b1;
            PCWrite    = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUOp  = (r_cls == C_IMM) ? 2'b11 : 2'b10;
        ALUSrc = (r_cls == C_IMM);
        w_next = S_WB_R;
      end
      S_WB_R: begin
        ALUOp    = (r_cls == C_IMM) ? 2'b11 : 2'b10;
        ALUSrc   = (r_cls == C_IMM);
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXEC_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = (r_cls == C_ST);
        w_next  = S_MEM;
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (r_cls == C_LD);
        MemWrite = (r_cls == C_ST);
        if (dmem_ready) begin
          if (r_cls == C_LD) begin
            w_next = S_WB_L;
          end else begin
            PCWrite = 1'b1;
            w_next  = S_FETCH;
          end
        end else if (w_tmo) begin
          ExcBusErr = 1'b1;
          MemWrite  = 1'b0;
          w_next    = S_FETCH;
        end
      end
      S_WB_L: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXEC_BR: begin
        Reg2Loc = 1'b1;
        ALUOp   = 2'b01;
        PCWrite = 1'b1;
        PCSrc   = Zero;
        w_next  = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      IMemReq    = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      Reg2Loc    = 1'b0;
      ALUSrc     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      ALUOp      = 2'b00;
      ExcInvalid = 1'b0;
      ExcBusErr  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_cls       <= C_INV;
      r_wait      <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      r_state     <= w_next;
      cycle_count <= cycle_count + 1'b1;
      if (r_state == S_DECODE) r_cls <= w_cls;
      if (PCWrite && !ExcInvalid) instr_count <= instr_count + 1'b1;
      if (!w_wait || w_tmo || (w_next != r_state)) r_wait <= '0;
      else                                         r_wait <= r_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, wait states,
// memory timeout, invalid opcodes and mid-instruction reset.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset, Zero, imem_ready, dmem_ready;
  logic [10:0] Op;
  logic        IMemReq, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, ExcInvalid, ExcBusErr;
  logic [1:0]  ALUOp;
  logic [31:0] cycle_count, instr_count;
  logic        n_IMemReq, n_IRWrite, n_PCWrite, n_PCSrc, n_Reg2Loc, n_ALUSrc, n_MemtoReg;
  logic        n_RegWrite, n_MemRead, n_MemWrite, n_ExcInvalid, n_ExcBusErr;
  logic [1:0]  n_ALUOp;
  logic [31:0] n_cycle_count, n_instr_count;
  logic [13:0] ctl;
  int          checks = 0;
  int          errors = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;
  // {IMemReq,IRWrite, PCWrite,PCSrc, Reg2Loc,ALUSrc,MemtoReg,RegWrite, MemRead,MemWrite, ALUOp, ExcInvalid,ExcBusErr}
  localparam logic [13:0] F_RDY  = {2'b11, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] F_WAIT = {2'b10, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] IDLE   = 14'b0;

  assign ctl = {IMemReq, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, ALUOp, ExcInvalid, ExcBusErr};

  always #5 clk = ~clk;

  multicycle_ctrl #(.IMM_EN(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemReq(IMemReq), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
    .ExcInvalid(ExcInvalid), .ExcBusErr(ExcBusErr),
    .cycle_count(cycle_count), .instr_count(instr_count));

  multicycle_ctrl #(.IMM_EN(0)) dut_noimm (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemReq(n_IMemReq), .IRWrite(n_IRWrite), .PCWrite(n_PCWrite), .PCSrc(n_PCSrc),
    .Reg2Loc(n_Reg2Loc), .ALUSrc(n_ALUSrc), .MemtoReg(n_MemtoReg), .RegWrite(n_RegWrite),
    .MemRead(n_MemRead), .MemWrite(n_MemWrite), .ALUOp(n_ALUOp),
    .ExcInvalid(n_ExcInvalid), .ExcBusErr(n_ExcBusErr),
    .cycle_count(n_cycle_count), .instr_count(n_instr_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [13:0] exp);
    #1;
    chk(tag, 64'(ctl), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; Zero = 1'b0; Op = OP_ADD;
    tick(); tick();
    chk_ctl("rst_ctl", IDLE);
    chk("rst_cyc", 64'(cycle_count), 64'd0);
    chk("rst_ins", 64'(instr_count), 64'd0);
    reset = 1'b0;

    chk_ctl("add_fetch", F_RDY);                                  tick();
    chk_ctl("add_decode", IDLE);                                  tick();
    chk_ctl("add_exec", {2'b00, 2'b00, 4'b0000, 2'b00, 2'b10, 2'b00}); tick();
    chk_ctl("add_wb",   {2'b00, 2'b10, 4'b0001, 2'b00, 2'b10, 2'b00}); tick();
    chk("add_ins", 64'(instr_count), 64'd1);
    chk("add_cyc", 64'(cycle_count), 64'd4);

    Op = OP_LDUR;
    chk_ctl("ld_fetch", F_RDY);                                   tick();
    chk_ctl("ld_decode", IDLE);                                   tick();
    chk_ctl("ld_addr", {2'b00, 2'b00, 4'b0100, 2'b00, 2'b00, 2'b00});
    dmem_ready = 1'b0;                                            tick();
    for (int i = 0; i < 3; i++) begin
      chk_ctl("ld_mem_wait", {2'b00, 2'b00, 4'b0100, 2'b10, 2'b00, 2'b00}); tick();
    end
    dmem_ready = 1'b1;
    chk_ctl("ld_mem_rdy", {2'b00, 2'b00, 4'b0100, 2'b10, 2'b00, 2'b00}); tick();
    chk_ctl("ld_wb",      {2'b00, 2'b10, 4'b0011, 2'b00, 2'b00, 2'b00}); tick();
    chk("ld_cyc", 64'(cycle_count), 64'd12);
    chk("ld_ins", 64'(instr_count), 64'd2);

    Op = OP_CBZ; Zero = 1'b1;
    chk_ctl("cbz1_fetch", F_RDY);                                 tick();
    chk_ctl("cbz1_decode", IDLE);                                 tick();
    chk_ctl("cbz1_br", {2'b00, 2'b11, 4'b1000, 2'b00, 2'b01, 2'b00}); tick();
    Zero = 1'b0;
    chk_ctl("cbz0_fetch", F_RDY);                                 tick();
    chk_ctl("cbz0_decode", IDLE);                                 tick();
    chk_ctl("cbz0_br", {2'b00, 2'b10, 4'b1000, 2'b00, 2'b01, 2'b00}); tick();
    chk("cbz_ins", 64'(instr_count), 64'd4);

    Op = OP_BAD;
    chk_ctl("inv_fetch", F_RDY);                                  tick();
    chk_ctl("inv_decode", {2'b00, 2'b10, 4'b0000, 2'b00, 2'b00, 2'b10}); tick();
    chk("inv_ins", 64'(instr_count), 64'd4);
    Op = OP_B;
    chk_ctl("b_fetch", F_RDY);                                    tick();
    chk_ctl("b_decode", {2'b00, 2'b11, 4'b0000, 2'b00, 2'b00, 2'b00}); tick();
    chk("b_ins", 64'(instr_count), 64'd5);

    Op = 11'bx;
    chk_ctl("x_fetch", F_RDY);                                    tick();
    chk_ctl("x_decode", {2'b00, 2'b10, 4'b0000, 2'b00, 2'b00, 2'b10}); tick();
    chk("x_ins", 64'(instr_count), 64'd5);

    Op = OP_ADDI;
    chk_ctl("addi_fetch", F_RDY);                                 tick();
    chk_ctl("addi_decode", IDLE);
    chk("noimm_addi_inv", 64'(n_ExcInvalid), 64'd1);              tick();
    chk_ctl("addi_exec", {2'b00, 2'b00, 4'b0100, 2'b00, 2'b11, 2'b00}); tick();
    chk_ctl("addi_wb",   {2'b00, 2'b10, 4'b0101, 2'b00, 2'b11, 2'b00}); tick();
    Op = OP_SUBI;
    chk_ctl("subi_fetch", F_RDY);                                 tick();
    chk_ctl("subi_decode", IDLE);                                 tick();
    chk_ctl("subi_exec", {2'b00, 2'b00, 4'b0100, 2'b00, 2'b11, 2'b00}); tick();
    chk_ctl("subi_wb",   {2'b00, 2'b10, 4'b0101, 2'b00, 2'b11, 2'b00}); tick();
    chk("imm_cyc", 64'(cycle_count), 64'd32);
    chk("imm_ins", 64'(instr_count), 64'd7);

    Op = OP_STUR; imem_ready = 1'b0;
    for (int i = 0; i < 199; i++) begin
      chk_ctl("tmo_wait", F_WAIT); tick();
    end
    chk_ctl("tmo_buserr", {2'b10, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b01}); tick();
    chk("tmo_ins", 64'(instr_count), 64'd7);
    for (int i = 0; i < 199; i++) begin
      chk_ctl("tmo_wait2", F_WAIT); tick();
    end
    imem_ready = 1'b1;
    chk_ctl("tmo_ready_wins", F_RDY);                             tick();
    chk_ctl("st_decode", IDLE);                                   tick();
    chk_ctl("st_addr", {2'b00, 2'b00, 4'b1100, 2'b00, 2'b00, 2'b00});
    dmem_ready = 1'b0;                                            tick();
    chk_ctl("st_mem_wait", {2'b00, 2'b00, 4'b0100, 2'b01, 2'b00, 2'b00});
    reset = 1'b1;
    chk_ctl("st_mem_rst", IDLE);                                  tick();
    chk("st_rst_cyc", 64'(cycle_count), 64'd0);
    chk("st_rst_ins", 64'(instr_count), 64'd0);
    reset = 1'b0; dmem_ready = 1'b1;
    chk_ctl("st2_fetch", F_RDY);                                  tick();
    chk_ctl("st2_decode", IDLE);                                  tick();
    chk_ctl("st2_addr", {2'b00, 2'b00, 4'b1100, 2'b00, 2'b00, 2'b00}); tick();
    chk_ctl("st2_mem",  {2'b00, 2'b10, 4'b0100, 2'b01, 2'b00, 2'b00}); tick();
    chk("st2_ins", 64'(instr_count), 64'd1);
    chk("st2_cyc", 64'(cycle_count), 64'd4);
    chk_ctl("st2_back_fetch", F_RDY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
